// File: rtl/spart_rx.sv
// spart_rx: 16x oversampled async serial receiver (8N1, LSB first) with rda/overrun/framing flags.
// Latency: rx_data/rda update in the clk cycle of the 16th baud_clk pulse of the stop bit.
// Backpressure: none; an unread byte is overwritten and flagged via sticky ovr (cleared by rd).
// Optional build macro SPART_RX_FRAME_CHECK_EN: when defined, ferr reports a low stop bit.
module spart_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       baud_clk,
  input  logic       rxd,
  input  logic       rd,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       ovr,
  output logic       ferr
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t     state;
  logic [3:0] tick;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       rx_s1;
  logic       rxs;
  logic       rxs_prev;
  logic       done;

  // Byte completes on the 16th baud pulse of the stop bit.
  assign done = baud_clk && (state == STOP) && (tick == 4'd15);

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rxs   <= rx_s1;
    end
  end

  // Frame FSM; everything, including the start-edge history, advances only on baud pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick     <= 4'd0;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      rxs_prev <= 1'b1;
    end else if (baud_clk) begin
      rxs_prev <= rxs;
      case (state)
        IDLE: begin
          if (en && rxs_prev && !rxs) begin
            state <= START;
            tick  <= 4'd0;
          end
        end
        START: begin
          if (tick == 4'd7) begin
            // Mid start bit: a high line means the edge was a glitch.
            tick    <= 4'd0;
            bit_cnt <= 3'd0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            tick <= tick + 4'd1;
          end
        end
        DATA: begin
          tick <= tick + 4'd1;
          if (tick == 4'd15) begin
            shift   <= {rxs, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          tick <= tick + 4'd1;
          if (tick == 4'd15) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register and flags; completion takes priority over a same-cycle read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data <= 8'h00;
      rda     <= 1'b0;
      ovr     <= 1'b0;
    end else if (done) begin
      rx_data <= shift;
      rda     <= 1'b1;
      ovr     <= ovr | rda;
    end else if (rd && rda) begin
      rda <= 1'b0;
      ovr <= 1'b0;
    end
  end

`ifdef SPART_RX_FRAME_CHECK_EN
  // Framing error tracks the stop bit of the byte currently held in rx_data.
  always_ff @(posedge clk) begin
    if (rst)       ferr <= 1'b0;
    else if (done) ferr <= ~rxs;
  end
`else
  assign ferr = 1'b0;
`endif

endmodule

// File: tb/tb_spart_rx.sv
module tb_spart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       baud_clk;
  logic       rxd;
  logic       rd;
  logic [7:0] rx_data;
  logic       rda;
  logic       ovr;
  logic       ferr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spart_rx dut (
    .clk(clk), .rst(rst), .en(en), .baud_clk(baud_clk), .rxd(rxd), .rd(rd),
    .rx_data(rx_data), .rda(rda), .ovr(ovr), .ferr(ferr)
  );

  // One baud tick = two clk cycles, baud_clk high in the first.
  // nbits < 10 sends a truncated frame; pause_clks holds baud_clk low before data bit 3;
  // rd_tick/en_off_tick pulse rd / drop en on that tick index (-1 = never).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int nbits,
                            input int pause_clks, input int rd_tick, input int en_off_tick);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int j = 0; j < nbits; j++) begin
      for (int t = 0; t < 16; t++) begin
        if (j == 4 && t == 0) repeat (pause_clks) @(negedge clk);
        @(negedge clk);
        if (t == 0) rxd = frame[j];
        rd = ((j * 16 + t) == rd_tick);
        if ((j * 16 + t) == en_off_tick) en = 1'b0;
        baud_clk = 1'b1;
        @(negedge clk);
        baud_clk = 1'b0;
        rd = 1'b0;
      end
    end
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); baud_clk = 1'b1;
      @(negedge clk); baud_clk = 1'b0;
    end
  endtask

  task automatic read_pulse();
    @(negedge clk); rd = 1'b1;
    @(negedge clk); rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; baud_clk = 1'b0; rxd = 1'b1; rd = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL reset_rda: got %b want 0", rda); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", ovr); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", ferr); end
  endtask

  task automatic test_basic();
    en = 1'b1;
    idle_ticks(4);
    send_frame(8'h55, 1'b1, 10, 0, -1, -1);
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL basic_data: got %h want 55", rx_data); end
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL basic_rda: got %b want 1", rda); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL basic_ovr: got %b want 0", ovr); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b want 0", ferr); end
  endtask

  task automatic test_read();
    read_pulse();
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL read_rda: got %b want 0", rda); end
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL read_data: got %h want 55", rx_data); end
    read_pulse();
    checks++; if (rda !== 1'b0 || ovr !== 1'b0) begin errors++; $display("FAIL read_idle: got rda=%b ovr=%b want 0 0", rda, ovr); end
  endtask

  task automatic test_overrun();
    send_frame(8'h00, 1'b1, 10, 0, -1, -1);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL ovr_first_data: got %h want 00", rx_data); end
    checks++; if (rda !== 1'b1 || ovr !== 1'b0) begin errors++; $display("FAIL ovr_first_flags: got rda=%b ovr=%b want 1 0", rda, ovr); end
    send_frame(8'hA3, 1'b1, 10, 0, -1, -1);
    checks++; if (rx_data !== 8'hA3) begin errors++; $display("FAIL ovr_second_data: got %h want a3", rx_data); end
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", ovr); end
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL ovr_rda: got %b want 1", rda); end
    read_pulse();
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL ovr_rd_rda: got %b want 0", rda); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_rd_ovr: got %b want 0", ovr); end
  endtask

  task automatic test_glitch();
    @(negedge clk); rxd = 1'b0;
    idle_ticks(4);
    @(negedge clk); rxd = 1'b1;
    idle_ticks(20);
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL glitch_rda: got %b want 0", rda); end
    checks++; if (rx_data !== 8'hA3) begin errors++; $display("FAIL glitch_data: got %h want a3", rx_data); end
    send_frame(8'h3C, 1'b1, 10, 0, -1, -1);
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL glitch_next_data: got %h want 3c", rx_data); end
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL glitch_next_rda: got %b want 1", rda); end
    read_pulse();
  endtask

  task automatic test_frame_err();
    logic exp_ferr;
`ifdef SPART_RX_FRAME_CHECK_EN
    exp_ferr = 1'b1;
`else
    exp_ferr = 1'b0;
`endif
    send_frame(8'hFF, 1'b0, 10, 0, -1, -1);
    checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL ferr_data: got %h want ff", rx_data); end
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL ferr_rda: got %b want 1", rda); end
    checks++; if (ferr !== exp_ferr) begin errors++; $display("FAIL ferr_flag: got %b want %b", ferr, exp_ferr); end
    @(negedge clk); rxd = 1'b1;
    idle_ticks(4);
    read_pulse();
    send_frame(8'h0F, 1'b1, 10, 0, -1, -1);
    checks++; if (rx_data !== 8'h0F) begin errors++; $display("FAIL ferr_next_data: got %h want 0f", rx_data); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL ferr_next_flag: got %b want 0", ferr); end
    read_pulse();
  endtask

  task automatic test_freeze();
    send_frame(8'h5A, 1'b1, 10, 41, -1, -1);
    checks++; if (rx_data !== 8'h5A || rda !== 1'b1) begin errors++; $display("FAIL freeze_data: got %h rda=%b want 5a 1", rx_data, rda); end
    read_pulse();
  endtask

  task automatic test_enable();
    en = 1'b0;
    send_frame(8'h12, 1'b1, 10, 0, -1, -1);
    checks++; if (rda !== 1'b0 || rx_data !== 8'h5A) begin errors++; $display("FAIL en_block: got %h rda=%b want 5a 0", rx_data, rda); end
    en = 1'b1;
    idle_ticks(2);
    send_frame(8'h34, 1'b1, 10, 0, -1, 40);
    checks++; if (rx_data !== 8'h34 || rda !== 1'b1) begin errors++; $display("FAIL en_midframe: got %h rda=%b want 34 1", rx_data, rda); end
    send_frame(8'h77, 1'b1, 10, 0, -1, -1);
    checks++; if (rx_data !== 8'h34 || ovr !== 1'b0) begin errors++; $display("FAIL en_off_block: got %h ovr=%b want 34 0", rx_data, ovr); end
    en = 1'b1;
    idle_ticks(2);
  endtask

  task automatic test_reset_mid();
    send_frame(8'h96, 1'b1, 5, 0, -1, -1);
    @(negedge clk); rst = 1'b1; rxd = 1'b1;
    @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", rx_data); end
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL rstmid_rda: got %b want 0", rda); end
    checks++; if (ovr !== 1'b0 || ferr !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got ovr=%b ferr=%b want 0 0", ovr, ferr); end
    rst = 1'b0;
    idle_ticks(20);
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL rstmid_partial: got rda=%b want 0", rda); end
    send_frame(8'h81, 1'b1, 10, 0, -1, -1);
    checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL rstmid_next_data: got %h want 81", rx_data); end
    checks++; if (rda !== 1'b1 || ovr !== 1'b0) begin errors++; $display("FAIL rstmid_next_flags: got rda=%b ovr=%b want 1 0", rda, ovr); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h42, 1'b1, 10, 0, -1, -1);
    checks++; if (rx_data !== 8'h42 || ovr !== 1'b1) begin errors++; $display("FAIL b2b_first: got %h ovr=%b want 42 1", rx_data, ovr); end
    // rd lands on tick 153, the stop-bit completion cycle.
    send_frame(8'hE7, 1'b1, 10, 0, 153, -1);
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL rdcomp_rda: got %b want 1", rda); end
    checks++; if (rx_data !== 8'hE7) begin errors++; $display("FAIL rdcomp_data: got %h want e7", rx_data); end
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL rdcomp_ovr: got %b want 1", ovr); end
    read_pulse();
    checks++; if (rda !== 1'b0 || ovr !== 1'b0) begin errors++; $display("FAIL final_rd: got rda=%b ovr=%b want 0 0", rda, ovr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_read();
    test_overrun();
    test_glitch();
    test_frame_err();
    test_freeze();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
